// File: rtl/msi_pkg.sv
// Shared encodings for the MSI snooping cache controller:
// bus messages, per-line coherence states and controller FSM states.
package msi_pkg;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_RDX  = 2'b01,
        BUS_UPGR = 2'b10,
        BUS_NONE = 2'b11
    } bus_msg_e;

    typedef enum logic [1:0] {
        LINE_I = 2'b00,
        LINE_S = 2'b01,
        LINE_M = 2'b10
    } line_state_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_GNT = 2'b01,
        ST_OWN      = 2'b10
    } fsm_state_e;

    // Coherence reaction of a valid line whose tag matches a snooped message.
    function automatic line_state_e snoop_next(line_state_e cur, bus_msg_e msg);
        line_state_e nxt;
        nxt = cur;
        case (msg)
            BUS_RD:            if (cur == LINE_M) nxt = LINE_S;
            BUS_RDX, BUS_UPGR: nxt = LINE_I;
            default:           nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/msi_snoop_ctrl_if.sv
// Processor request, arbiter handshake and snooped-bus signals of the
// MSI controller. The slave modport is the controller's view.
interface msi_snoop_ctrl_if #(
    parameter int ADDR_SIZE = 32
);
    logic                 test_rd_i;
    logic                 test_wr_i;
    logic [ADDR_SIZE-1:0] test_addr_i;
    logic                 done_o;
    logic                 pr_bus_req_o;
    logic                 pr_bus_req_i;
    logic [1:0]           bus_msg_o;
    logic [ADDR_SIZE-1:0] addr_o;
    logic                 flush_o;
    logic                 bus_valid_i;
    logic [1:0]           bus_msg_i;
    logic [ADDR_SIZE-1:0] addr_i;

    modport slave (
        input  test_rd_i, test_wr_i, test_addr_i, pr_bus_req_i,
               bus_valid_i, bus_msg_i, addr_i,
        output done_o, pr_bus_req_o, bus_msg_o, addr_o, flush_o
    );

    modport master (
        output test_rd_i, test_wr_i, test_addr_i, pr_bus_req_i,
               bus_valid_i, bus_msg_i, addr_i,
        input  done_o, pr_bus_req_o, bus_msg_o, addr_o, flush_o
    );
endinterface

// File: rtl/msi_tag_array.sv
// Direct-mapped tag/state storage. One combinational lookup port for the
// controller, one write port for completed bus transactions and one
// snoop-update port. A snoop hitting the written line in the same cycle wins.
module msi_tag_array
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 2,
    parameter int ADDR_SIZE = 32,
    localparam int IDX_W = $clog2(NUM_LINES),
    localparam int TAG_W = ADDR_SIZE - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE-1:0] lookup_addr,
    output line_state_e          lookup_state,
    output logic                 lookup_match,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  line_state_e          wr_state,
    input  logic                 snoop_en,
    input  bus_msg_e             snoop_msg,
    input  logic [ADDR_SIZE-1:0] snoop_addr
);
    line_state_e      line_state [NUM_LINES];
    logic [TAG_W-1:0] line_tag   [NUM_LINES];

    logic [IDX_W-1:0] lookup_idx, wr_idx, snoop_idx;
    logic [TAG_W-1:0] lookup_tag, wr_tag, snoop_tag;

    assign lookup_idx = lookup_addr[IDX_W-1:0];
    assign lookup_tag = lookup_addr[ADDR_SIZE-1:IDX_W];
    assign wr_idx     = wr_addr[IDX_W-1:0];
    assign wr_tag     = wr_addr[ADDR_SIZE-1:IDX_W];
    assign snoop_idx  = snoop_addr[IDX_W-1:0];
    assign snoop_tag  = snoop_addr[ADDR_SIZE-1:IDX_W];

    assign lookup_state = line_state[lookup_idx];
    assign lookup_match = (line_tag[lookup_idx] == lookup_tag);

    // Line storage: transaction fill first, snoop update last so it takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                line_state[i] <= LINE_I;
                line_tag[i]   <= '0;
            end
        end else begin
            if (wr_en) begin
                line_tag[wr_idx]   <= wr_tag;
                line_state[wr_idx] <= wr_state;
            end
            if (snoop_en && (line_tag[snoop_idx] == snoop_tag)) begin
                line_state[snoop_idx] <= snoop_next(line_state[snoop_idx], snoop_msg);
            end
        end
    end

endmodule

// File: rtl/msi_snoop_ctrl.sv
// MSI snooping cache controller: services processor reads/writes from the
// local tag array, requests the bus on misses/upgrades, and reacts to
// transactions snooped from other caches.
module msi_snoop_ctrl
    import msi_pkg::*;
#(
    parameter int NUM_LINES = 2,
    parameter int ADDR_SIZE = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    msi_snoop_ctrl_if.slave bus
);
    fsm_state_e           state, state_next;
    logic                 op_wr;
    logic [ADDR_SIZE-1:0] op_addr;
    logic                 done_q;

    logic [ADDR_SIZE-1:0] lookup_addr;
    line_state_e          lookup_state;
    logic                 lookup_match;
    logic                 req_any, req_wr, idle_hit;
    bus_msg_e             own_msg, msg_out;
    logic                 req_out, flush_out;
    logic [ADDR_SIZE-1:0] addr_out;
    logic                 wr_en, snoop_en;
    line_state_e          wr_state;

    assign req_any     = bus.test_rd_i | bus.test_wr_i;
    assign req_wr      = bus.test_wr_i;
    assign lookup_addr = (state == ST_IDLE) ? bus.test_addr_i : op_addr;
    assign snoop_en    = bus.bus_valid_i && (state != ST_OWN);
    assign idle_hit    = lookup_match &&
                         (req_wr ? (lookup_state == LINE_M) : (lookup_state != LINE_I));

    msi_tag_array #(
        .NUM_LINES (NUM_LINES),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_tags (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .lookup_addr  (lookup_addr),
        .lookup_state (lookup_state),
        .lookup_match (lookup_match),
        .wr_en        (wr_en),
        .wr_addr      (op_addr),
        .wr_state     (wr_state),
        .snoop_en     (snoop_en),
        .snoop_msg    (bus_msg_e'(bus.bus_msg_i)),
        .snoop_addr   (bus.addr_i)
    );

    // Message for the pending operation, re-evaluated each cycle so a snoop that invalidates an S line turns an upgrade into BusRdX.
    always_comb begin
        own_msg = BUS_RDX;
        if (!op_wr) begin
            own_msg = BUS_RD;
        end else if (lookup_match && (lookup_state == LINE_S)) begin
            own_msg = BUS_UPGR;
        end
    end

    // State register, captured operation and registered completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            op_wr   <= 1'b0;
            op_addr <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= ((state == ST_IDLE) && req_any && idle_hit) || (state == ST_OWN);
            if ((state == ST_IDLE) && req_any) begin
                op_wr   <= req_wr;
                op_addr <= bus.test_addr_i;
            end
        end
    end

    // Next-state and bus-side outputs; the line is filled at the end of OWN.
    always_comb begin
        state_next = state;
        req_out    = 1'b0;
        msg_out    = BUS_NONE;
        addr_out   = '0;
        flush_out  = 1'b0;
        wr_en      = 1'b0;
        wr_state   = LINE_I;
        case (state)
            ST_IDLE: begin
                if (req_any && !idle_hit) state_next = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                req_out  = 1'b1;
                msg_out  = own_msg;
                addr_out = op_addr;
                if (bus.pr_bus_req_i) state_next = ST_OWN;
            end
            ST_OWN: begin
                msg_out    = own_msg;
                addr_out   = op_addr;
                flush_out  = (lookup_state == LINE_M) && !lookup_match;
                wr_en      = 1'b1;
                wr_state   = (own_msg == BUS_RD) ? LINE_S : LINE_M;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.done_o       = done_q;
    assign bus.pr_bus_req_o = req_out;
    assign bus.bus_msg_o    = msg_out;
    assign bus.addr_o       = addr_out;
    assign bus.flush_o      = flush_out;

    // A grant is only meaningful while this controller is waiting for one.
    grant_only_when_waiting: assert property (
        @(posedge clk_i) disable iff (!rst_ni) bus.pr_bus_req_i |-> (state == ST_WAIT_GNT)
    );

endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// Self-checking bench for msi_snoop_ctrl: directed scenarios followed by
// randomized processor operations and snoops, compared against a
// line-by-line model that remembers which full address each line holds.
module tb_msi_snoop_ctrl;
    import msi_pkg::*;

    localparam int NL = 2;
    localparam int AW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    line_state_e     m_st   [NL];
    logic [AW-1:0]   m_addr [NL];

    msi_snoop_ctrl_if #(.ADDR_SIZE(AW)) bus ();

    msi_snoop_ctrl #(
        .NUM_LINES (NL),
        .ADDR_SIZE (AW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int lineOf(logic [AW-1:0] a);
        return int'(a % NL);
    endfunction

    function automatic bit modelHit(bit wr, logic [AW-1:0] a);
        int i = lineOf(a);
        if (m_addr[i] != a) return 1'b0;
        return wr ? (m_st[i] == LINE_M) : (m_st[i] != LINE_I);
    endfunction

    function automatic logic [1:0] modelMsg(bit wr, logic [AW-1:0] a);
        int i = lineOf(a);
        if (!wr) return BUS_RD;
        if ((m_addr[i] == a) && (m_st[i] == LINE_S)) return BUS_UPGR;
        return BUS_RDX;
    endfunction

    task automatic modelSnoop(logic [1:0] msg, logic [AW-1:0] a);
        int i = lineOf(a);
        if (m_addr[i] == a) begin
            if ((msg == BUS_RD) && (m_st[i] == LINE_M)) m_st[i] = LINE_S;
            if ((msg == BUS_RDX) || (msg == BUS_UPGR)) m_st[i] = LINE_I;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NL; i++) begin
            m_st[i]   = LINE_I;
            m_addr[i] = AW'(i);
        end
    endtask

    task automatic checkLines(string tag);
        for (int i = 0; i < NL; i++) begin
            checkOutput({tag, "_state"}, 64'(dut.u_tags.line_state[i]), 64'(m_st[i]));
            checkOutput({tag, "_tag"}, 64'(dut.u_tags.line_tag[i]), 64'(m_addr[i] / NL));
        end
    endtask

    task automatic checkIdle(string tag, bit expDone);
        checkOutput({tag, "_done"}, bus.done_o, expDone);
        checkOutput({tag, "_req"}, bus.pr_bus_req_o, 1'b0);
        checkOutput({tag, "_msg"}, bus.bus_msg_o, BUS_NONE);
        checkOutput({tag, "_addr"}, bus.addr_o, '0);
        checkOutput({tag, "_flush"}, bus.flush_o, 1'b0);
    endtask

    task automatic driveSnoop(logic [1:0] msg, logic [AW-1:0] a);
        bus.bus_valid_i = 1'b1;
        bus.bus_msg_i   = msg;
        bus.addr_i      = a;
    endtask

    // Called just after the edge that sampled a driven snoop.
    task automatic settleSnoop();
        if (bus.bus_valid_i) modelSnoop(bus.bus_msg_i, bus.addr_i);
        bus.bus_valid_i = 1'b0;
        bus.bus_msg_i   = BUS_NONE;
    endtask

    task automatic randomSnoop();
        driveSnoop(2'($urandom_range(3, 0)), AW'($urandom_range(15, 0)));
    endtask

    // One idle cycle, optionally with a snoop (random when rnd is set).
    task automatic idleCycle(bit en, bit rnd, logic [1:0] msg, logic [AW-1:0] a);
        if (en) driveSnoop(msg, a);
        else if (rnd && ($urandom_range(1, 0) == 1)) randomSnoop();
        @(posedge clk); #1;
        settleSnoop();
        checkIdle("idle", 1'b0);
    endtask

    // One processor operation from IDLE to completion; called at posedge+1.
    task automatic applyStimulus(bit rd, bit wr, logic [AW-1:0] a, int waitCycles,
                                 bit snpEn, logic [1:0] snpMsg, logic [AW-1:0] snpAddr,
                                 bit rnd);
        int         i;
        bit         hit;
        logic [1:0] expMsg;
        bit         expFlush;
        i   = lineOf(a);
        hit = modelHit(wr, a);
        bus.test_rd_i   = rd;
        bus.test_wr_i   = wr;
        bus.test_addr_i = a;
        @(posedge clk); #1;
        bus.test_rd_i   = 1'b0;
        bus.test_wr_i   = 1'b0;
        bus.test_addr_i = AW'($urandom_range(15, 0));
        if (hit) begin
            checkOutput("hit_done", bus.done_o, 1'b1);
            checkOutput("hit_req", bus.pr_bus_req_o, 1'b0);
            checkOutput("hit_msg", bus.bus_msg_o, BUS_NONE);
            return;
        end
        checkOutput("wait_req", bus.pr_bus_req_o, 1'b1);
        checkOutput("wait_done", bus.done_o, 1'b0);
        checkOutput("wait_msg", bus.bus_msg_o, modelMsg(wr, a));
        checkOutput("wait_addr", bus.addr_o, a);
        for (int c = 0; c < waitCycles; c++) begin
            if ((c == 0) && snpEn) driveSnoop(snpMsg, snpAddr);
            else if (rnd && ($urandom_range(1, 0) == 1)) randomSnoop();
            bus.test_rd_i = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
            @(posedge clk); #1;
            bus.test_rd_i = 1'b0;
            settleSnoop();
            checkOutput("wait_req_hold", bus.pr_bus_req_o, 1'b1);
            checkOutput("wait_msg_hold", bus.bus_msg_o, modelMsg(wr, a));
        end
        expMsg   = modelMsg(wr, a);
        expFlush = (m_st[i] == LINE_M) && (m_addr[i] != a);
        bus.pr_bus_req_i = 1'b1;
        @(posedge clk); #1;
        bus.pr_bus_req_i = 1'b0;
        if (rnd) randomSnoop();
        checkOutput("own_req", bus.pr_bus_req_o, 1'b0);
        checkOutput("own_msg", bus.bus_msg_o, expMsg);
        checkOutput("own_addr", bus.addr_o, a);
        checkOutput("own_flush", bus.flush_o, expFlush);
        checkOutput("own_done", bus.done_o, 1'b0);
        @(posedge clk); #1;
        bus.bus_valid_i = 1'b0;
        bus.bus_msg_i   = BUS_NONE;
        m_addr[i] = a;
        m_st[i]   = (expMsg == BUS_RD) ? LINE_S : LINE_M;
        checkIdle("end", 1'b1);
    endtask

    initial begin
        bus.test_rd_i    = 1'b0;
        bus.test_wr_i    = 1'b0;
        bus.test_addr_i  = '0;
        bus.pr_bus_req_i = 1'b0;
        bus.bus_valid_i  = 1'b0;
        bus.bus_msg_i    = BUS_NONE;
        bus.addr_i       = '0;
        modelReset();

        #2;
        $display("[TB] reset state");
        checkIdle("reset", 1'b0);
        checkLines("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] read miss 0x4 then re-read hit");
        applyStimulus(1, 0, 32'h4, 1, 0, BUS_NONE, '0, 0);
        checkOutput("r37_line0", dut.u_tags.line_state[0], LINE_S);
        applyStimulus(1, 0, 32'h4, 0, 0, BUS_NONE, '0, 0);
        idleCycle(0, 0, BUS_NONE, '0);
        checkLines("r37");

        $display("[TB] upgrade converted by snooped BusRdX");
        applyStimulus(0, 1, 32'h4, 2, 1, BUS_RDX, 32'h4, 0);
        checkOutput("r38_line0", dut.u_tags.line_state[0], LINE_M);
        checkLines("r38");

        $display("[TB] dirty victim flushed");
        applyStimulus(1, 0, 32'h6, 1, 0, BUS_NONE, '0, 0);
        checkLines("r39");

        $display("[TB] snoop transitions on line 1");
        applyStimulus(0, 1, 32'h3, 0, 0, BUS_NONE, '0, 0);
        idleCycle(1, 0, BUS_RDX, 32'h7);
        checkLines("r40_other");
        idleCycle(1, 0, BUS_RD, 32'h3);
        checkLines("r40_rd");
        idleCycle(1, 0, BUS_RDX, 32'h3);
        checkLines("r40_rdx");

        $display("[TB] simultaneous rd and wr miss");
        applyStimulus(1, 1, 32'h2, 1, 0, BUS_NONE, '0, 0);
        checkLines("r42");

        $display("[TB] hit with concurrent snoop on same line");
        bus.test_rd_i   = 1'b1;
        bus.test_addr_i = 32'h2;
        driveSnoop(BUS_RD, 32'h2);
        @(posedge clk); #1;
        bus.test_rd_i = 1'b0;
        settleSnoop();
        checkOutput("r28_done", bus.done_o, 1'b1);
        checkOutput("r28_req", bus.pr_bus_req_o, 1'b0);
        idleCycle(0, 0, BUS_NONE, '0);
        checkLines("r28");

        $display("[TB] reset during WAIT_GNT");
        bus.test_rd_i   = 1'b1;
        bus.test_addr_i = 32'h5;
        @(posedge clk); #1;
        bus.test_rd_i = 1'b0;
        checkOutput("r41_req_before", bus.pr_bus_req_o, 1'b1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkIdle("r41_async", 1'b0);
        checkLines("r41");
        bus.pr_bus_req_i = 1'b1;
        @(posedge clk); #1;
        bus.pr_bus_req_i = 1'b0;
        checkIdle("r41_grant_ignored", 1'b0);
        rst_n = 1'b1;
        idleCycle(0, 0, BUS_NONE, '0);
        checkLines("r41_after");
        applyStimulus(1, 0, 32'h5, 0, 0, BUS_NONE, '0, 0);
        checkLines("r41_reuse");

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [AW-1:0] a;
            kind = int'($urandom_range(2, 0));
            a    = AW'($urandom_range(15, 0));
            applyStimulus(kind != 1, kind != 0, a, int'($urandom_range(3, 0)),
                          0, BUS_NONE, '0, 1);
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
                idleCycle(0, 1, BUS_NONE, '0);
            end
            checkLines("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/msi_snoop_ctrl.md
MSI_SNOOP_CTRL -- requirements
Module: msi_snoop_ctrl

Interface
REQ-001 Parameter NUM_LINES, default 2, number of direct-mapped cache lines (power of two, >=2).
REQ-002 Parameter ADDR_SIZE, default 32, width of the line address.
REQ-003 clk_i  in  1  the single clock.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 test_rd_i  in  1  processor read request, sampled only in IDLE.
REQ-006 test_wr_i  in  1  processor write request, sampled only in IDLE; wins if test_rd_i is also high.
REQ-007 test_addr_i  in  ADDR_SIZE  processor line address.
REQ-008 done_o  out  1  one-cycle pulse when the captured operation completes.
REQ-009 pr_bus_req_o  out  1  bus request to the arbiter.
REQ-010 pr_bus_req_i  in  1  grant, one-cycle pulse from the arbiter.
REQ-011 bus_msg_o  out  2  message driven while requesting or owning the bus.
REQ-012 addr_o  out  ADDR_SIZE  address driven with bus_msg_o.
REQ-013 flush_o  out  1  victim writeback, high only in the OWN cycle.
REQ-014 bus_valid_i  in  1  bus carries a valid transaction this cycle.
REQ-015 bus_msg_i  in  2  snooped message.
REQ-016 addr_i  in  ADDR_SIZE  snooped address.

Function
REQ-017 Bus messages SHALL be encoded 2'b00 BusRd, 2'b01 BusRdX, 2'b10 BusUpgr, 2'b11 none.
REQ-018 Index SHALL be addr[log2(NUM_LINES)-1:0]; tag SHALL be the remaining upper bits; each line SHALL hold a tag and state I/S/M.
REQ-019 The FSM SHALL have states IDLE, WAIT_GNT and OWN.
REQ-020 In IDLE with a request, the controller SHALL capture op/address; a read hit (S/M) or a write hit in M SHALL pulse done_o the next cycle with no bus request, and a write hit SHALL leave the line in M.
REQ-021 Any other request SHALL move to WAIT_GNT; pr_bus_req_o SHALL be high throughout WAIT_GNT.
REQ-022 In WAIT_GNT, bus_msg_o SHALL be recomputed every cycle from the current line state: read -> BusRd; write with tag match in S -> BusUpgr; otherwise write -> BusRdX; addr_o = captured address.
REQ-023 A grant in WAIT_GNT SHALL move to OWN the next cycle; pr_bus_req_o SHALL drop in OWN.
REQ-024 In OWN, flush_o SHALL be 1 iff the indexed line is M with a different tag.
REQ-025 At the end of OWN, the line SHALL be updated (tag written; BusRd -> S; BusRdX/BusUpgr -> M), done_o SHALL pulse the next cycle, and the FSM SHALL return to IDLE.
REQ-026 Outside OWN, with bus_valid_i and tag match on addr_i: BusRd turns M -> S; BusRdX/BusUpgr turn S/M -> I; other states are unchanged.
REQ-027 Snooping SHALL be disabled in OWN (own transaction).
REQ-028 Snoop and processor hit on the same line in the same cycle: the hit completes, and the snoop update wins the line state.
REQ-029 A snoop invalidating the awaited S line in WAIT_GNT SHALL convert the pending BusUpgr to BusRdX per REQ-022.
REQ-030 A grant outside WAIT_GNT SHALL be ignored and flagged by an assertion.
REQ-031 Request inputs outside IDLE SHALL be ignored.
REQ-032 bus_msg_o SHALL be 2'b11 and addr_o SHALL be 0 in IDLE.

Reset
REQ-033 Reset assertion SHALL immediately force IDLE, all lines I, all tags 0, done_o/pr_bus_req_o/flush_o 0, bus_msg_o 2'b11 and addr_o 0, including mid-operation.
REQ-034 The first request SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-035 Package msi_pkg SHALL hold the bus message encodings, the line-state enum (I/S/M) and the FSM state enum.
REQ-036 The tag/state storage with its snoop-update port SHALL be sub-module msi_tag_array.

Verification
REQ-037 Read 0x4 from reset, grant 2 cycles after the request -> BusRd/0x4 in WAIT_GNT, done_o 1 cycle after OWN, line 0 = S; re-read 0x4 -> done_o next cycle, no request.
REQ-038 Line 0 S for 0x4; write 0x4 -> BusUpgr; before grant, snoop BusRdX 0x4 -> bus_msg_o becomes BusRdX; after OWN, line = M.
REQ-039 Line 0 M for 0x4; read 0x6 -> OWN cycle shows BusRd 0x6 with flush_o=1; line 0 = S with tag of 0x6.
REQ-040 Line 1 M for 0x3; snoop BusRd 0x3 -> S; snoop BusRdX 0x3 -> I; snoop 0x7 -> unchanged.
REQ-041 Reset asserted in WAIT_GNT -> pr_bus_req_o=0 asynchronously, all lines I; later grant pulse ignored.
REQ-042 test_rd_i=test_wr_i=1 on a miss to 0x2 -> BusRdX issued; line ends M.
